// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon 32/64 key schedule and cipher pipeline.
package simon_pkg;

    localparam int WORD_W   = 16;
    localparam int KEY_W    = 64;
    localparam int N_ROUNDS = 32;

    // z0[j] lives at Z0[61-j]: the leftmost bit of the published sequence is z0[0].
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef logic [WORD_W-1:0] rk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic rk_t ror(input rk_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// One Simon 32/64 key-schedule word update: k[i] from k[i-4], k[i-3], k[i-1] and z0 bit.
module simon_key_step
    import simon_pkg::*;
(
    input  logic [15:0] k_im4,
    input  logic [15:0] k_im3,
    input  logic [15:0] k_im1,
    input  logic        z,
    output logic [15:0] k_i
);

    logic [15:0] t0;
    logic [15:0] t1;

    assign t0  = ror(k_im1, 3) ^ k_im3;
    assign t1  = t0 ^ ror(t0, 1);
    assign k_i = 16'hFFFC ^ {15'b0, z} ^ k_im4 ^ t1;

endmodule

// File: rtl/simon_key_schedule.sv
// Iterative Simon 32/64 key expansion: one round key per clock into a held packed array.
//
//   state | meaning
//   IDLE  | after reset, no keys available
//   GEN   | expansion running, one word written per cycle
//   DONE  | all round keys valid and held
module simon_key_schedule #(
    parameter int N_ROUNDS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [63:0]                keytext,
    output logic [N_ROUNDS-1:0][15:0]  key,
    output logic                       key_valid,
    output logic                       busy
);

    import simon_pkg::*;

    localparam int                IDX_W     = $clog2(N_ROUNDS);
    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(4);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_ROUNDS - 1);

    state_t                      state;
    logic [IDX_W-1:0]            idx;
    logic [N_ROUNDS-1:0][15:0]   key_q;
    logic [5:0]                  z_j;
    logic [5:0]                  z_pos;
    logic                        z_bit;
    logic [15:0]                 k_next;

    // idx is only meaningful in GEN (idx >= 4); elsewhere the step output is ignored.
    assign z_j   = 6'(idx) - 6'd4;
    assign z_pos = 6'd61 - z_j;
    assign z_bit = Z0[z_pos];

    simon_key_step u_step (
        .k_im4 (key_q[idx - IDX_W'(4)]),
        .k_im3 (key_q[idx - IDX_W'(3)]),
        .k_im1 (key_q[idx - IDX_W'(1)]),
        .z     (z_bit),
        .k_i   (k_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            key_q     <= '0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_q[0]  <= keytext[15:0];
                        key_q[1]  <= keytext[31:16];
                        key_q[2]  <= keytext[47:32];
                        key_q[3]  <= keytext[63:48];
                        idx       <= IDX_FIRST;
                        busy      <= 1'b1;
                        key_valid <= 1'b0;
                        state     <= GEN;
                    end
                end
                GEN: begin
                    key_q[idx] <= k_next;
                    if (idx == IDX_LAST) begin
                        busy      <= 1'b0;
                        key_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    busy      <= 1'b0;
                    key_valid <= 1'b0;
                end
            endcase
        end
    end

    assign key = key_q;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Self-checking bench for simon_key_schedule against a software Simon 32/64 key-schedule model.
module tb_simon_key_schedule;

    localparam int N = 32;

    logic               clk;
    logic               rst;
    logic               start;
    logic [63:0]        keytext;
    logic [N-1:0][15:0] key;
    logic               key_valid;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mk [N];
    string z0s = "11111010001001010110000111001101111101000100101011000011100110";

    simon_key_schedule #(.N_ROUNDS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .keytext   (keytext),
        .key       (key),
        .key_valid (key_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
        logic [15:0] r;
        r = (x >> n) | (x << (16 - n));
        return r;
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
        logic [15:0] r;
        r = (x << n) | (x >> (16 - n));
        return r;
    endfunction

    task automatic build_model(input logic [63:0] kt);
        logic [15:0] t;
        for (int i = 0; i < 4; i++) mk[i] = kt[16*i +: 16];
        for (int i = 4; i < N; i++) begin
            t = rotr(mk[i-1], 3) ^ mk[i-3];
            t = t ^ rotr(t, 1);
            mk[i] = 16'hFFFC ^ mk[i-4] ^ t ^ ((z0s[i-4] == "1") ? 16'h0001 : 16'h0000);
        end
    endtask

    function automatic logic [31:0] encrypt_with_dut_keys(input logic [31:0] pt);
        logic [15:0] x, y, tmp;
        x = pt[31:16];
        y = pt[15:0];
        for (int r = 0; r < N; r++) begin
            tmp = x;
            x = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ key[r];
            y = tmp;
        end
        return {x, y};
    endfunction

    task automatic check_words(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_w%0d", tag, i), 64'(key[i]), 64'(mk[i]));
    endtask

    // Caller sets timing away from an edge; start is raised now and accepted on the next edge.
    task automatic run_expansion(input string tag, input logic [63:0] kt,
                                 input bit hold_start, input bit zap_key_at_e5);
        int lat;
        build_model(kt);
        keytext = kt;
        start   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        check({tag, "_e0_w0"}, 64'(key[0]), 64'(kt[15:0]));
        check({tag, "_e0_w1"}, 64'(key[1]), 64'(kt[31:16]));
        check({tag, "_e0_w2"}, 64'(key[2]), 64'(kt[47:32]));
        check({tag, "_e0_w3"}, 64'(key[3]), 64'(kt[63:48]));
        check({tag, "_e0_busy"}, 64'(busy), 64'd1);
        check({tag, "_e0_valid"}, 64'(key_valid), 64'd0);
        lat = 0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk);
            #1;
            if (zap_key_at_e5 && e == 5) keytext = 64'd0;
            if (key_valid) begin
                lat = e;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(N - 4));
        check({tag, "_done_busy"}, 64'(busy), 64'd0);
        check_words(tag);
    endtask

    initial begin
        logic [N-1:0][15:0] snap;
        logic [63:0] rk;

        rst     = 1'b1;
        start   = 1'b1;
        keytext = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(key_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_words_zero", 64'(key == '0), 64'd1);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_valid", 64'(key_valid), 64'd0);

        @(negedge clk);
        run_expansion("nominal", 64'h1918111009080100, 1'b0, 1'b0);
        check("cipher", 64'(encrypt_with_dut_keys(32'h65656877)), 64'hc69be9bb);

        snap = key;
        keytext = {$urandom, $urandom};
        repeat (5) @(posedge clk);
        #1;
        check("hold_stable", 64'(key == snap), 64'd1);
        check("hold_valid", 64'(key_valid), 64'd1);

        @(negedge clk);
        run_expansion("ignored", 64'h1918111009080100, 1'b1, 1'b1);

        @(negedge clk);
        keytext = {$urandom, $urandom};
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midgen_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check("abort_valid", 64'(key_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_words_zero", 64'(key == '0), 64'd1);

        @(negedge clk);
        run_expansion("zero", 64'd0, 1'b0, 1'b0);
        check("zero_word4", 64'(key[4]), 64'hFFFD);

        @(negedge clk);
        run_expansion("ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

        // Back-to-back random expansions: each start lands on the first DONE cycle.
        for (int r = 0; r < 4; r++) begin
            rk = {$urandom, $urandom};
            run_expansion($sformatf("rand%0d", r), rk, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simon_key_schedule.md
# simon_key_schedule

Iterative key-expansion engine for Simon 32/64. It sits directly upstream of `simon_pipeline`. It takes the 64-bit master key, produces the full set of 16-bit round keys one word per clock, and presents them as the packed `key` array that the pipeline consumes. Results are held stable behind a `key_valid` flag, so one expansion serves any number of subsequent plaintext blocks.

## Interface
- `N_ROUNDS`, default 32: number of round keys produced. Legal range is 5..62; 32 is the only value used by `simon_pipeline`.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request an expansion of `keytext`. Sampled on a rising edge.
- `keytext`  in  64: master key. Captured only on an accepted `start`.
- `key`  out  [N_ROUNDS-1:0][15:0]: round keys, with `key[i]` = round key i.
- `key_valid`  out  1: high while `key` holds a complete expansion.
- `busy`  out  1: high while an expansion is in progress.

## Operation
- Three states.
  - IDLE: after reset, no keys available.
  - GEN: expansion running.
  - DONE: keys valid and held.
- Accepted `start`: `start`=1 in IDLE or DONE.
  - Load `key[0]`=keytext[15:0], `key[1]`=[31:16], `key[2]`=[47:32], `key[3]`=[63:48].
  - Set `idx`=4, `busy`=1, `key_valid`=0, and go to GEN.
- In GEN, each cycle computes `key[idx]` from the previous four words.
  - t = ror3(`key[idx-1]`) ^ `key[idx-3]`
  - t = t ^ ror1(t)
  - `key[idx]` = 16'hFFFC ^ {15'b0, z0[idx-4]} ^ `key[idx-4]` ^ t
- Then `idx` increments.
- When `idx`=N_ROUNDS-1 is written, go to DONE, with `busy`=0 and `key_valid`=1.
- z0 is the 62-bit sequence 11111010001001010110000111001101111101000100101011000011100110, where z0[0] is the leftmost bit. The constant is stored MSB-first and indexed as Z0[61-j].
- All arithmetic is 16-bit XOR and rotate only. Rotations are right rotations modulo 16. There is no carry or width growth.
- Boundary rules:
  - `start` in GEN is ignored, whether held or pulsed. The capture, state and `idx` are unaffected.
  - Changes to `keytext` after the accepted edge are ignored.
  - `start` in DONE restarts the expansion. `key_valid` falls on that edge, and words 4..N-1 keep their old values until overwritten.
  - `rst` dominates `start` on the same edge.
  - `rst` mid-GEN aborts the expansion. The block returns to IDLE with outputs at reset values.
- While GEN is running, `key` shows partially updated words. Consumers must qualify `key` with `key_valid`.

## Timing
- Reset values: `key_valid`=0, `busy`=0, every `key[i]`=16'h0000, state IDLE, `idx`=0.
- Let edge E0 be the edge that accepts `start`.
  - After E0: words 0..3 are loaded and `busy`=1.
  - Edges E1..E(N-4) each write one word. For N=32 that is E1..E28.
  - After E(N-4): `key_valid`=1 and `busy`=0. Latency from accepting `start` to `key_valid` is N-4 = 28 edges.
- Back-to-back operation: `start` on the first DONE cycle is accepted, giving another 28-edge latency.
- `key` changes only on E0..E(N-4), and is constant while `key_valid`=1.

## Structure
- Package `simon_pkg` holds:
  - `WORD_W`=16, `KEY_W`=64, `N_ROUNDS`=32, and the 62-bit `Z0` constant.
  - `typedef logic [15:0] rk_t`.
  - The `ror` function.
  - The state enum (IDLE/GEN/DONE).
  - `simon_pipeline` imports the same package.
- Sub-module `simon_key_step`: a purely combinational single-word update. Inputs are k[i-4], k[i-3], k[i-1] and the z bit; output is k[i]. The top level handles the FSM, counter, storage and write-enable decode.
- The previous four words are read by indexing the storage array with `idx-1`, `idx-3` and `idx-4`. No separate shift register is used.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → `key_valid`=0, `busy`=0, all 32 words 0x0000, and `start` during reset is ignored.
- Nominal expansion: `keytext`=0x1918111009080100 with a single-cycle `start`.
  - After E0: words 0..3 are 0x0100, 0x0908, 0x1110, 0x1918, and `busy`=1.
  - `key_valid` rises exactly 28 edges after E0.
  - All 32 words match the software golden model.
- End-to-end: connect `key` to `simon_pipeline` and apply plaintext 0x65656877 after `key_valid` → ciphertext 0xc69be9bb.
- Ignored start: hold `start` high throughout GEN and change `keytext` to 0 at E5 → same 32 words and the same latency as the nominal case.
- Mid-run reset: assert `rst` at E10 → IDLE with all words 0. Then `start` with `keytext`=0 → word 4 = 0xFFFC ^ z0[0] = 0xFFFD, and `key_valid` rises 28 edges after that `start`.
- Restart from DONE: a new `keytext`=0xFFFFFFFFFFFFFFFF → `key_valid` falls on E0, words 0..3 become 0xFFFF, and valid rises 28 edges later with a result matching the model.
